// File: rtl/ttl_pkg.sv
// Shared definitions for the 74xx-family counter models: nibble width, nibble type,
// and the per-nibble step/terminal-count helpers used by each 4-bit slice.
package ttl_pkg;

  localparam int TTL_NIBBLE = 4;

  typedef logic [3:0] ttl_nib_t;

  // Next value of a counting nibble; dn selects decrement (wraps 0 -> F).
  function automatic ttl_nib_t nib_step(input ttl_nib_t q, input logic dn);
    if (dn) begin
      return q - 4'd1;
    end
    return q + 4'd1;
  endfunction

  // Terminal count is the value from which the next count carries or borrows.
  function automatic logic nib_terminal(input ttl_nib_t q, input logic dn);
    if (dn) begin
      return (q == 4'h0);
    end
    return (q == 4'hF);
  endfunction

endpackage

// File: rtl/ttl_cnt4_stage.sv
// One 4-bit 74161-style slice: sync load, ENP/ENT enables, combinational RCO.
// Macro TTL_CNT_UPDOWN_EN adds the DN direction input.
module ttl_cnt4_stage
  import ttl_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     LOAD_N,
  input  logic     ENP,
  input  logic     ENT,
`ifdef TTL_CNT_UPDOWN_EN
  input  logic     DN,
`endif
  input  ttl_nib_t D,
  output ttl_nib_t Q,
  output logic     RCO
);

  ttl_nib_t q_reg;
  ttl_nib_t q_next;
  logic     dir_dn;

`ifdef TTL_CNT_UPDOWN_EN
  assign dir_dn = DN;
`else
  assign dir_dn = 1'b0;
`endif

  // Load beats count; counting needs both enables.
  always_comb begin
    q_next = q_reg;
    if (!LOAD_N) begin
      q_next = D;
    end else if (ENP && ENT) begin
      q_next = nib_step(q_reg, dir_dn);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q   = q_reg;
  // RCO ignores ENP and LOAD_N so a cascade's carry lookahead stays purely ENT-driven.
  assign RCO = ENT & nib_terminal(q_reg, dir_dn);

endmodule

// File: rtl/ttl_sync_counter_161.sv
// Cascadable WIDTH-bit synchronous counter built from 4-bit 74161 slices chained via RCO->ENT.
// Macro TTL_CNT_UPDOWN_EN adds the DN direction input (broadcast to every slice).
module ttl_sync_counter_161
  import ttl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
`ifdef TTL_CNT_UPDOWN_EN
  input  logic             DN,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam int NSLICE = WIDTH / TTL_NIBBLE;

  if (((WIDTH % TTL_NIBBLE) != 0) || (WIDTH < TTL_NIBBLE)) begin : g_bad_width
    $error("ttl_sync_counter_161: WIDTH must be a multiple of 4 and at least 4");
  end

  // ent_chain[k] is slice k's ENT; ent_chain[NSLICE] is the last slice's RCO.
  logic [NSLICE:0] ent_chain;

  assign ent_chain[0] = ENT;

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    ttl_cnt4_stage u_stage (
      .CLK    (CLK),
      .RST    (RST),
      .LOAD_N (LOAD_N),
      .ENP    (ENP),
      .ENT    (ent_chain[k]),
`ifdef TTL_CNT_UPDOWN_EN
      .DN     (DN),
`endif
      .D      (D[k*TTL_NIBBLE +: TTL_NIBBLE]),
      .Q      (Q[k*TTL_NIBBLE +: TTL_NIBBLE]),
      .RCO    (ent_chain[k+1])
    );
  end

  assign RCO = ent_chain[NSLICE];

endmodule

// File: tb/tb_ttl_sync_counter_161.sv
// Directed bench for ttl_sync_counter_161: a WIDTH=4 and a WIDTH=8 instance share the controls.
module tb_ttl_sync_counter_161;

  logic       clk;
  logic       rst;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic       dn;
  logic [7:0] d8;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       rco4;
  logic       rco8;

  int total  = 0;
  int passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ttl_sync_counter_161 #(.WIDTH(4)) u4 (
    .CLK    (clk),
    .RST    (rst),
    .LOAD_N (load_n),
    .ENP    (enp),
    .ENT    (ent),
`ifdef TTL_CNT_UPDOWN_EN
    .DN     (dn),
`endif
    .D      (d8[3:0]),
    .Q      (q4),
    .RCO    (rco4)
  );

  ttl_sync_counter_161 #(.WIDTH(8)) u8 (
    .CLK    (clk),
    .RST    (rst),
    .LOAD_N (load_n),
    .ENP    (enp),
    .ENT    (ent),
`ifdef TTL_CNT_UPDOWN_EN
    .DN     (dn),
`endif
    .D      (d8),
    .Q      (q8),
    .RCO    (rco8)
  );

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    int rco_cnt;
    int seq_err;
    rst = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0; dn = 1'b0; d8 = 8'h00;
    @(negedge clk);
    tick();
    check("reset_q4", {4'h0, q4}, 8'h00);
    check("reset_q8", q8, 8'h00);
    ent = 1'b1;
    #1;
    check("reset_rco4", {7'd0, rco4}, 8'h00);

    // Release reset with counting enabled: first edge gives 1.
    @(negedge clk);
    rst = 1'b0; enp = 1'b1; ent = 1'b1;
    tick();
    check("post_reset_q4", {4'h0, q4}, 8'h01);
    check("post_reset_q8", q8, 8'h01);

    // Async reset between edges while at 7.
    load_n = 1'b0; d8 = 8'h07;
    tick();
    check("load7_q4", {4'h0, q4}, 8'h07);
    load_n = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_q4", {4'h0, q4}, 8'h00);
    check("async_rst_q8", q8, 8'h00);
    tick();
    check("rst_hold_q4", {4'h0, q4}, 8'h00);
    rst = 1'b0;
    tick();
    check("rst_release_q4", {4'h0, q4}, 8'h01);

    // Reset during a pending load discards the load.
    load_n = 1'b0; d8 = 8'h09; rst = 1'b1;
    tick();
    check("rst_vs_load_q4", {4'h0, q4}, 8'h00);
    rst = 1'b0; load_n = 1'b1; enp = 1'b0;
    tick();
    check("load_lost_q4", {4'h0, q4}, 8'h00);

    // Load has priority over count.
    load_n = 1'b0; d8 = 8'h0A; enp = 1'b1; ent = 1'b1;
    tick();
    check("load_a_q4", {4'h0, q4}, 8'h0A);
    load_n = 1'b1;
    tick();
    check("count_b_q4", {4'h0, q4}, 8'h0B);

    // Enable gating and RCO at terminal count.
    load_n = 1'b0; d8 = 8'h0F; enp = 1'b0; ent = 1'b1;
    tick();
    check("load_f_q4", {4'h0, q4}, 8'h0F);
    check("load_f_rco4", {7'd0, rco4}, 8'h01);
    load_n = 1'b1;
    tick();
    check("enp0_hold_q4", {4'h0, q4}, 8'h0F);
    check("enp0_rco4", {7'd0, rco4}, 8'h01);
    ent = 1'b0;
    #1;
    check("ent0_rco4", {7'd0, rco4}, 8'h00);
    @(negedge clk);
    enp = 1'b1; ent = 1'b1;
    tick();
    check("wrap_q4", {4'h0, q4}, 8'h00);
    check("wrap_rco4", {7'd0, rco4}, 8'h00);

    // Cascade at WIDTH=8.
    load_n = 1'b0; d8 = 8'h0F; enp = 1'b0;
    tick();
    check("load0f_q8", q8, 8'h0F);
    check("load0f_rco8", {7'd0, rco8}, 8'h00);
    load_n = 1'b1; enp = 1'b1;
    tick();
    check("carry_q8", q8, 8'h10);
    load_n = 1'b0; d8 = 8'hFF;
    tick();
    check("loadff_q8", q8, 8'hFF);
    check("loadff_rco8", {7'd0, rco8}, 8'h01);
    load_n = 1'b1;
    tick();
    check("wrap_q8", q8, 8'h00);
    check("wrap_rco8", {7'd0, rco8}, 8'h00);

    // Full 256-edge sweep from 0.
    rco_cnt = 0;
    seq_err = 0;
    for (int i = 0; i < 256; i++) begin
      if (rco8) rco_cnt++;
      if (q8 !== 8'(i)) seq_err++;
      tick();
    end
    check("sweep_q8", q8, 8'h00);
    check("sweep_rco_cycles", 8'(rco_cnt), 8'd1);
    check("sweep_seq_errors", 8'(seq_err), 8'd0);

`ifdef TTL_CNT_UPDOWN_EN
    // Down counting: 1 -> 0 (terminal) -> F.
    load_n = 1'b0; d8 = 8'h01; enp = 1'b0; dn = 1'b1;
    tick();
    load_n = 1'b1; enp = 1'b1;
    tick();
    check("dn_q4_zero", {4'h0, q4}, 8'h00);
    check("dn_rco4_zero", {7'd0, rco4}, 8'h01);
    tick();
    check("dn_q4_wrap", {4'h0, q4}, 8'h0F);
    check("dn_rco4_wrap", {7'd0, rco4}, 8'h00);
    check("dn_q8_wrap", q8, 8'hFF);
    load_n = 1'b0; d8 = 8'h00; enp = 1'b0;
    tick();
    load_n = 1'b1;
    check("dn_rco8_zero", {7'd0, rco8}, 8'h01);
    dn = 1'b0;
    #1;
    check("up_retarget_rco4", {7'd0, rco4}, 8'h00);
    check("up_retarget_rco8", {7'd0, rco8}, 8'h00);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
